uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Req0_Valid,
  input  logic       i_Req1_Valid,
  input  logic [7:0] i_Req0_Byte,
  input  logic [7:0] i_Req1_Byte,
  output logic       o_Req0_Ready,
  output logic       o_Req1_Ready,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic [1:0] o_Grant,
  output logic       o_Busy,
  output logic       o_Timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  localparam int MAX_CNT_V  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = (MAX_CNT_V < 1) ? 1 : $clog2(MAX_CNT_V + 1);
  localparam int GAP_LAST_V = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LAST_V);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
`ifdef UART_ARB_TIMEOUT_EN
  localparam int               TO_LAST_V = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_V);
`endif

  logic [1:0]       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             dv_q, dv_d;
  logic             busy_q, busy_d;
  logic             run_q, run_d;

  logic             grant_ok_s;
  logic             pick1_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             accept_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_SAT) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Round-robin pick; run_q keeps Ready low through and just after reset.
  always_comb begin
    grant_ok_s = run_q && (state_q == S_IDLE) && !i_Tx_Active;
    if (i_Req0_Valid && i_Req1_Valid) begin
      pick1_s = ~last_q;
    end else if (i_Req1_Valid) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    ready0_s = grant_ok_s && i_Req0_Valid && !pick1_s;
    ready1_s = grant_ok_s && i_Req1_Valid && pick1_s;
    accept_s = ready0_s || ready1_s;
  end

  // Next-state and datapath updates for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    dv_d      = 1'b0;
    run_d     = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_LAUNCH;
          byte_d  = ready1_s ? i_Req1_Byte : i_Req0_Byte;
          grant_d = ready1_s ? 2'b10 : 2'b01;
          last_d  = ready1_s;
          dv_d    = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d   = CNT_ZERO;
      end
      S_WAIT: begin
        if (i_Tx_Done) begin
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          grant_d = 2'b00;
          cnt_d   = CNT_ZERO;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q >= TO_LAST) begin
          // Watchdog expiry skips the gap entirely.
          state_d   = S_IDLE;
          grant_d   = 2'b00;
          cnt_d     = CNT_ZERO;
          timeout_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
`else
        else begin
          cnt_d = cnt_q;
        end
`endif
      end
      S_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
        cnt_d   = CNT_ZERO;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers; reset leaves Req1 as last served so Req0 wins first.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      byte_q    <= 8'h00;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      cnt_q     <= CNT_ZERO;
      timeout_q <= 1'b0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
      run_q     <= run_d;
    end
  end

  assign o_Req0_Ready = ready0_s;
  assign o_Req1_Ready = ready1_s;
  assign o_Tx_DV      = dv_q;
  assign o_Tx_Byte    = byte_q;
  assign o_Grant      = grant_q;
  assign o_Busy       = busy_q;
  assign o_Timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; expected {grant,byte} queued at drive time.
module tb_uart_tx_arbiter;

  localparam int GAP = 4;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] b0 = 8'h00, b1 = 8'h00;
  logic       ready0, ready1, tx_dv, busy, timeout;
  logic [7:0] tx_byte;
  logic       tx_active = 1'b0, tx_done = 1'b0;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;
  int dv_seen = 0;
  int dv_exp = 0;
  logic [9:0] exp_q[$];
  logic prev_dv = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_Req0_Valid(v0), .i_Req1_Valid(v1),
    .i_Req0_Byte(b0), .i_Req1_Byte(b1),
    .o_Req0_Ready(ready0), .o_Req1_Ready(ready1),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
    .o_Grant(grant), .o_Busy(busy), .o_Timeout(timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] g, input logic [7:0] b);
    exp_q.push_back({g, b});
    dv_exp++;
  endtask

  // Monitor: every start pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (tx_dv) begin
      check_eq("dv_width", {30'd0, prev_dv, tx_dv}, 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("dv_unexpected", 32'd1, {31'd0, 1'b0} + {24'd0, tx_byte} + 32'd0 - {24'd0, tx_byte});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check_eq("tx_byte", {24'd0, tx_byte}, {24'd0, e[7:0]});
        check_eq("tx_grant", {30'd0, grant}, {30'd0, e[9:8]});
      end
      dv_seen <= dv_seen + 1;
    end
    prev_dv <= tx_dv;
  end

  task automatic do_reset();
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  // From IDLE (accept pending) through LAUNCH into the first WAIT_DONE cycle.
  task automatic launch(input bit drop);
    @(negedge clk); #1;
    check_eq("busy_launch", {31'd0, busy}, 32'd1);
    if (drop) begin
      v0 = 1'b0; v1 = 1'b0;
    end else begin
      v0 = v0; v1 = v1;
    end
    tx_active = 1'b1;
    @(negedge clk); #1;
  endtask

  // From WAIT_DONE: real done pulse, then count the gap clocks.
  task automatic finish_byte(input bit done_in_gap);
    int n;
    tx_done = 1'b1;
    @(negedge clk); #1;
    tx_done = 1'b0; tx_active = 1'b0;
    check_eq("grant_cleared", {30'd0, grant}, 32'd0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tx_done = (done_in_gap && n == 2);
      @(negedge clk); #1;
    end
    tx_done = 1'b0;
    check_eq("gap_cycles", n, GAP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state, with a requester already valid.
    v0 = 1'b1; b0 = 8'h41;
    repeat (2) @(negedge clk); #1;
    check_eq("rst_ready0", {31'd0, ready0}, 32'd0);
    check_eq("rst_dv", {31'd0, tx_dv}, 32'd0);
    check_eq("rst_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("rst_grant", {30'd0, grant}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
    v0 = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;

    // Single request 0x41.
    v0 = 1'b1; b0 = 8'h41; #1;
    check_eq("s1_ready0", {31'd0, ready0}, 32'd1);
    check_eq("s1_ready1", {31'd0, ready1}, 32'd0);
    push(2'b01, 8'h41);
    launch(1'b1);
    check_eq("s1_grant", {30'd0, grant}, 32'd1);
    // A valid that comes and goes while busy must not be queued.
    v1 = 1'b1; b1 = 8'h99; #1;
    check_eq("s1_no_ready_wait", {31'd0, ready1}, 32'd0);
    @(negedge clk); #1;
    v1 = 1'b0;
    finish_byte(1'b0);
    check_eq("s1_byte_hold", {24'd0, tx_byte}, 32'h41);

    // Contention after reset: 0x30, 0x31, 0x30.
    do_reset();
    v0 = 1'b1; b0 = 8'h30; v1 = 1'b1; b1 = 8'h31; #1;
    check_eq("s2_ready0_a", {31'd0, ready0}, 32'd1);
    check_eq("s2_ready1_a", {31'd0, ready1}, 32'd0);
    push(2'b01, 8'h30); push(2'b10, 8'h31); push(2'b01, 8'h30);
    launch(1'b0);
    finish_byte(1'b0);
    check_eq("s2_ready1_b", {31'd0, ready1}, 32'd1);
    check_eq("s2_ready0_b", {31'd0, ready0}, 32'd0);
    launch(1'b0);
    finish_byte(1'b0);
    check_eq("s2_ready0_c", {31'd0, ready0}, 32'd1);
    check_eq("s2_ready1_c", {31'd0, ready1}, 32'd0);
    launch(1'b1);
    finish_byte(1'b0);

    // Done during LAUNCH and during GAP is ignored.
    v0 = 1'b1; b0 = 8'h5A; #1;
    check_eq("s3_ready0", {31'd0, ready0}, 32'd1);
    push(2'b01, 8'h5A);
    @(negedge clk); #1;
    v0 = 1'b0; tx_done = 1'b1; tx_active = 1'b1;
    @(negedge clk); #1;
    tx_done = 1'b0;
    check_eq("s3_busy_after_early_done", {31'd0, busy}, 32'd1);
    check_eq("s3_grant_held", {30'd0, grant}, 32'd1);
    repeat (3) @(negedge clk); #1;
    check_eq("s3_still_waiting", {31'd0, busy}, 32'd1);
    finish_byte(1'b1);

    // Watchdog (or its absence) with done withheld.
    v1 = 1'b1; b1 = 8'hC3; #1;
    push(2'b10, 8'hC3);
    launch(1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (busy && n < 100) begin
        n++;
        @(negedge clk); #1;
      end
      check_eq("s4_wait_cycles", n, TO);
    end
    check_eq("s4_timeout_set", {31'd0, timeout}, 32'd1);
    check_eq("s4_grant_clr", {30'd0, grant}, 32'd0);
    tx_active = 1'b0;
    repeat (5) @(negedge clk); #1;
    check_eq("s4_timeout_sticky", {31'd0, timeout}, 32'd1);
    check_eq("s4_idle", {31'd0, busy}, 32'd0);
`else
    repeat (40) @(negedge clk); #1;
    check_eq("s4_wait_forever", {31'd0, busy}, 32'd1);
    check_eq("s4_grant_held", {30'd0, grant}, 32'd2);
    check_eq("s4_no_timeout", {31'd0, timeout}, 32'd0);
    finish_byte(1'b0);
`endif

    // Reset in WAIT_DONE with the transmitter still active.
    v0 = 1'b1; b0 = 8'h77; #1;
    push(2'b01, 8'h77);
    launch(1'b1);
    v1 = 1'b1; b1 = 8'hE4;
    #2 rst_n = 1'b0;
    #1;
    check_eq("s5_dv", {31'd0, tx_dv}, 32'd0);
    check_eq("s5_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("s5_grant", {30'd0, grant}, 32'd0);
    check_eq("s5_busy", {31'd0, busy}, 32'd0);
    check_eq("s5_timeout", {31'd0, timeout}, 32'd0);
    check_eq("s5_ready1_rst", {31'd0, ready1}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("s5_no_ready_active", {31'd0, ready1}, 32'd0);
    end
    tx_active = 1'b0; #1;
    check_eq("s5_ready1_after", {31'd0, ready1}, 32'd1);
    push(2'b10, 8'hE4);
    launch(1'b1);
    finish_byte(1'b0);

    repeat (3) @(negedge clk); #1;
    check_eq("dv_count", dv_seen, dv_exp);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
